// File: rtl/alarm_field.sv
// Modulo-(MAX_VAL+1) settable alarm field: button press/hold/auto-repeat stepping,
// direct clamped load, one-cycle wrap pulses and a registered alarm-match flag.
module alarm_field #(
    parameter int WIDTH      = 6,
    parameter int MAX_VAL    = 59,
    parameter int HOLD_CYC   = 6,
    parameter int REPEAT_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             arm,
    input  logic [WIDTH-1:0] time_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             match
);

    localparam int CMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [CW-1:0]    HOLD_C   = CW'(HOLD_CYC);
    localparam logic [CW-1:0]    REPEAT_C = CW'(REPEAT_CYC);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_dir_up, w_dir_up_nxt;
    logic          r_inc_q, r_dec_q;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          w_step, w_step_up, w_step_dn;
    logic          w_only_inc, w_only_dec, w_held;

    assign w_only_inc = inc_btn & ~dec_btn;
    assign w_only_dec = dec_btn & ~inc_btn;
    assign w_held     = r_dir_up ? w_only_inc : w_only_dec;
    assign w_cnt_inc  = r_cnt + 1'b1;

    // Button history keeps sampling through reset so a button held across
    // reset release is not mistaken for a fresh press.
    always_ff @(posedge clock) begin
        r_inc_q <= inc_btn;
        r_dec_q <= dec_btn;
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_up_nxt = r_dir_up;
        w_step       = 1'b0;
        if (load || !enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_only_inc && !r_inc_q) begin
                        w_state_nxt  = HOLD;
                        w_cnt_nxt    = '0;
                        w_dir_up_nxt = 1'b1;
                        w_step       = 1'b1;
                    end else if (w_only_dec && !r_dec_q) begin
                        w_state_nxt  = HOLD;
                        w_cnt_nxt    = '0;
                        w_dir_up_nxt = 1'b0;
                        w_step       = 1'b1;
                    end
                end
                HOLD, REPEAT: begin
                    if (!w_held) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == ((r_state == HOLD) ? HOLD_C : REPEAT_C)) begin
                        w_state_nxt = REPEAT;
                        w_cnt_nxt   = '0;
                        w_step      = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_step_up = w_step & w_dir_up_nxt;
        w_step_dn = w_step & ~w_dir_up_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count   <= '0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            match   <= 1'b0;
        end else begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            match   <= arm && (count == time_val);
            if (load) begin
                count <= (load_val > MAX_V) ? MAX_V : load_val;
            end else if (w_step_up) begin
                if (count == MAX_V) begin
                    count   <= '0;
                    wrap_up <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (w_step_dn) begin
                if (count == '0) begin
                    count   <= MAX_V;
                    wrap_dn <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_field.sv
// Directed self-checking bench for alarm_field at default parameters
// (WIDTH=6, MAX_VAL=59, HOLD_CYC=6, REPEAT_CYC=2).
module tb_alarm_field;

    logic       clock = 1'b0;
    logic       reset, enable, inc_btn, dec_btn, load, arm;
    logic [5:0] load_val, time_val;
    logic [5:0] count;
    logic       wrap_up, wrap_dn, match;

    int n_pass  = 0;
    int n_total = 0;

    alarm_field #(.WIDTH(6), .MAX_VAL(59), .HOLD_CYC(6), .REPEAT_CYC(2)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .inc_btn(inc_btn), .dec_btn(dec_btn),
        .load(load), .load_val(load_val),
        .arm(arm), .time_val(time_val),
        .count(count), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .match(match)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = 6'(v);
        step();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; inc_btn = 1'b1; dec_btn = 1'b1;
        load = 1'b0; load_val = '0; arm = 1'b0; time_val = '0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_wrap_up", wrap_up, 0);
        check("rst_wrap_dn", wrap_dn, 0);
        check("rst_match", match, 0);

        dec_btn = 1'b0; reset = 1'b1;
        step(); check("rst_release_held_a", count, 0);
        step(); check("rst_release_held_b", count, 0);
        inc_btn = 1'b0; step();

        do_load(10); check("load10", count, 10);
        inc_btn = 1'b1; step(); check("press_inc", count, 11);
        inc_btn = 1'b0; step(); check("release_inc", count, 11);
        dec_btn = 1'b1; step(); check("press_dec", count, 10);
        dec_btn = 1'b0; step(); check("release_dec", count, 10);

        do_load(59);
        inc_btn = 1'b1; step();
        check("wrap_up_count", count, 0);
        check("wrap_up_pulse", wrap_up, 1);
        inc_btn = 1'b0; step();
        check("wrap_up_width", wrap_up, 0);
        check("wrap_up_hold", count, 0);
        dec_btn = 1'b1; step();
        check("wrap_dn_count", count, 59);
        check("wrap_dn_pulse", wrap_dn, 1);
        check("wrap_dn_noup", wrap_up, 0);
        dec_btn = 1'b0; step();
        check("wrap_dn_width", wrap_dn, 0);

        // Steps at held edges 0,6,8,10,12,14 after the press.
        do_load(0);
        inc_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check($sformatf("repeat_i%0d", i), count, (i < 6) ? 1 : 2 + (i - 6) / 2);
        end
        inc_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("repeat_release", count, 6);
        end

        inc_btn = 1'b1; dec_btn = 1'b1; step(); check("both_press", count, 6);
        step(); check("both_hold", count, 6);
        inc_btn = 1'b0; dec_btn = 1'b0; step();

        inc_btn = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("into_repeat", count, 9);
        dec_btn = 1'b1; step(); check("second_btn_a", count, 9);
        step(); check("second_btn_b", count, 9);
        dec_btn = 1'b0; step(); check("idle_no_repress_a", count, 9);
        step(); step(); step(); check("idle_no_repress_b", count, 9);
        inc_btn = 1'b0; step();

        load = 1'b1; load_val = 6'd63; inc_btn = 1'b1; step();
        check("load_clamp", count, 59);
        check("load_clamp_nowrap", wrap_up, 0);
        load = 1'b0; step();
        check("load_then_held", count, 59);
        check("load_then_held_nowrap", wrap_up, 0);
        inc_btn = 1'b0; step();

        load = 1'b1; load_val = 6'd30; arm = 1'b1; time_val = 6'd30; step();
        load = 1'b0;
        check("match_latency_old", match, 0);
        step(); check("match_set", match, 1);
        arm = 1'b0; step(); check("match_disarm", match, 0);
        arm = 1'b1; step(); check("match_rearm", match, 1);
        time_val = 6'd31; step(); check("match_time_change", match, 0);

        enable = 1'b0;
        inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
        check("enable_low_freeze", count, 30);
        inc_btn = 1'b1; step();
        enable = 1'b1; step(); check("enable_rise_held", count, 30);
        step(); check("enable_rise_held_b", count, 30);
        inc_btn = 1'b0; step();
        inc_btn = 1'b1; step(); check("enable_press", count, 31);
        inc_btn = 1'b0; step();

        inc_btn = 1'b1;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b0; step(); check("reset_mid_repeat", count, 0);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("reset_mid_repeat_held", count, 0);
        inc_btn = 1'b0; step();
        inc_btn = 1'b1; step(); check("post_reset_press", count, 1);
        inc_btn = 1'b0; step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
